// File: rtl/sdram_port_arbiter.sv
// Multi-master front end for the sdram controller: arbitrates NCH stb/ack masters onto one
// level-sensitive we/rd port and owns the delayed controller-init / sdram_ready sequence.
module sdram_port_arbiter #(
  parameter int NCH        = 2,
  parameter int AW         = 21,
  parameter int DW         = 16,
  parameter int INIT_DELAY = 3,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk_p,
  input  logic              reset,
  input  logic [NCH-1:0]    ch_stb,
  input  logic [NCH-1:0]    ch_we,
  input  logic [2*NCH-1:0]  ch_sel,
  input  logic [NCH*AW-1:0] ch_adr,
  input  logic [NCH*DW-1:0] ch_wdat,
  output logic [DW-1:0]     ch_rdat,
  output logic [NCH-1:0]    ch_ack,
  output logic              sdram_ready,
  output logic              sdr_init,
  output logic              sdr_we,
  output logic              sdr_rd,
  output logic [1:0]        sdr_wtbt,
  output logic [AW-1:0]     sdr_addr,
  output logic [DW-1:0]     sdr_din,
  input  logic [DW-1:0]     sdr_dout,
  input  logic              sdr_ready
);

  localparam int          GW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned NCHU     = NCH;
  localparam logic [7:0]  INIT_CNT = 8'(INIT_DELAY);
  localparam logic [NCH-1:0] ACK_ONE = NCH'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]    state;
  logic          rst_q;
  logic [7:0]    init_cnt;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] grant_q;
  logic          we_q;

  logic [NCH-1:0] req_vec;
  logic [GW-1:0]  grant_idx;
  logic [GW-1:0]  ptr_next;
  logic           grant_any;
  logic [AW-1:0]  sel_adr;
  logic [DW-1:0]  sel_wdat;
  logic [1:0]     sel_sel;
  logic           sel_we;
  int unsigned    base;
  int unsigned    gsum;

  // rst_q plays the role of the old dreset: counting starts one edge after release,
  // so sdr_init falls INIT_DELAY+1 edges after the first edge with reset low.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      rst_q       <= 1'b1;
      init_cnt    <= '0;
      sdr_init    <= 1'b1;
      sdram_ready <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      if (!rst_q && init_cnt != INIT_CNT)
        init_cnt <= init_cnt + 8'd1;
      if (init_cnt == INIT_CNT)
        sdr_init <= 1'b0;
      if (!sdr_init && sdr_ready)
        sdram_ready <= 1'b1;
    end
  end

  // Round-robin rotates the request vector so the search always starts at bit 0.
  always_comb begin
    req_vec   = '0;
    base      = 0;
    gsum      = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    ptr_next  = '0;
    if (FIXED_PRIO != 0) begin
      req_vec = ch_stb;
      base    = 0;
    end else begin
      req_vec = NCH'({ch_stb, ch_stb} >> rr_ptr);
      base    = 32'(rr_ptr);
    end
    for (int unsigned i = 0; i < NCHU; i++) begin
      if (!grant_any && 1'(req_vec >> i)) begin
        grant_any = 1'b1;
        gsum      = base + i;
        if (gsum >= NCHU)
          gsum = gsum - NCHU;
        grant_idx = GW'(gsum);
      end
    end
    if (32'(grant_idx) + 1 >= NCHU)
      ptr_next = '0;
    else
      ptr_next = grant_idx + 1'b1;
    sel_adr  = AW'(ch_adr >> (32'(grant_idx) * AW));
    sel_wdat = DW'(ch_wdat >> (32'(grant_idx) * DW));
    sel_sel  = 2'(ch_sel >> (32'(grant_idx) * 2));
    sel_we   = 1'(ch_we >> grant_idx);
  end

  always_ff @(posedge clk_p) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      grant_q  <= '0;
      we_q     <= 1'b0;
      sdr_we   <= 1'b0;
      sdr_rd   <= 1'b0;
      sdr_wtbt <= '0;
      sdr_addr <= '0;
      sdr_din  <= '0;
      ch_ack   <= '0;
      ch_rdat  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ch_ack <= '0;
          if (sdram_ready && grant_any) begin
            grant_q  <= grant_idx;
            rr_ptr   <= ptr_next;
            we_q     <= sel_we;
            sdr_we   <= sel_we;
            sdr_rd   <= ~sel_we;
            sdr_wtbt <= sel_sel;
            sdr_addr <= sel_adr;
            sdr_din  <= sel_wdat;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!sdr_ready) begin
            sdr_we <= 1'b0;
            sdr_rd <= 1'b0;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (sdr_ready) begin
            if (!we_q)
              ch_rdat <= sdr_dout;
            ch_ack <= ACK_ONE << grant_q;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          ch_ack <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a round-robin instance (a_*) carries most scenarios,
// a fixed-priority instance (b_*) shares the data inputs for the arbitration comparison.
module tb_sdram_port_arbiter;
  localparam int NCH = 3;
  localparam int AW  = 21;
  localparam int DW  = 16;

  logic clk_p = 1'b0;
  always #5 clk_p = ~clk_p;

  logic              reset;
  logic [NCH-1:0]    stb_a, stb_b, we_v;
  logic [2*NCH-1:0]  sel_v;
  logic [NCH*AW-1:0] adr_v;
  logic [NCH*DW-1:0] wdat_v;
  logic [DW-1:0]     dout_v;
  logic              rdy_a, rdy_b;

  logic [DW-1:0]  a_rdat, b_rdat;
  logic [NCH-1:0] a_ack, b_ack;
  logic a_sready, a_init, a_we, a_rd, b_sready, b_init, b_we, b_rd;
  logic [1:0]     a_wtbt, b_wtbt;
  logic [AW-1:0]  a_addr, b_addr;
  logic [DW-1:0]  a_din, b_din;

  int n_cmp = 0;
  int n_bad = 0;

  sdram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .INIT_DELAY(3), .FIXED_PRIO(0)) dut_a (
    .clk_p(clk_p), .reset(reset), .ch_stb(stb_a), .ch_we(we_v), .ch_sel(sel_v),
    .ch_adr(adr_v), .ch_wdat(wdat_v), .ch_rdat(a_rdat), .ch_ack(a_ack),
    .sdram_ready(a_sready), .sdr_init(a_init), .sdr_we(a_we), .sdr_rd(a_rd),
    .sdr_wtbt(a_wtbt), .sdr_addr(a_addr), .sdr_din(a_din), .sdr_dout(dout_v),
    .sdr_ready(rdy_a));

  sdram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .INIT_DELAY(3), .FIXED_PRIO(1)) dut_b (
    .clk_p(clk_p), .reset(reset), .ch_stb(stb_b), .ch_we(we_v), .ch_sel(sel_v),
    .ch_adr(adr_v), .ch_wdat(wdat_v), .ch_rdat(b_rdat), .ch_ack(b_ack),
    .sdram_ready(b_sready), .sdr_init(b_init), .sdr_we(b_we), .sdr_rd(b_rd),
    .sdr_wtbt(b_wtbt), .sdr_addr(b_addr), .sdr_din(b_din), .sdr_dout(dout_v),
    .sdr_ready(rdy_b));

  task automatic step();
    @(posedge clk_p);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stb_a = '0; stb_b = '0; we_v = '0; sel_v = '0;
    adr_v = '0; wdat_v = '0; dout_v = '0; rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (5) step();
    n_cmp++; if (a_init !== 1'b1) begin n_bad++; $display("FAIL reset_init: got %b want 1", a_init); end
    n_cmp++; if (a_sready !== 1'b0) begin n_bad++; $display("FAIL reset_sdram_ready: got %b want 0", a_sready); end
    n_cmp++; if ({a_we, a_rd, a_ack} !== 5'b0) begin n_bad++; $display("FAIL reset_req_ack: got %b want 0", {a_we, a_rd, a_ack}); end
    n_cmp++; if ({a_rdat, a_wtbt, a_addr, a_din} !== '0) begin n_bad++; $display("FAIL reset_data: rdat=%h wtbt=%b addr=%h din=%h want all 0", a_rdat, a_wtbt, a_addr, a_din); end
  endtask

  // Leaves dut_a in REQ with the ch0 read granted; test_single_read continues it.
  task automatic test_init();
    adr_v[0 +: AW] = 21'h012345; we_v[0] = 1'b0; sel_v[1:0] = 2'b11;
    stb_a = 3'b001;
    reset = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step();
      n_cmp++; if (a_init !== (n < 5)) begin n_bad++; $display("FAIL init_sdr_init edge %0d: got %b want %b", n, a_init, (n < 5)); end
      n_cmp++; if (a_sready !== (n >= 6)) begin n_bad++; $display("FAIL init_sdram_ready edge %0d: got %b want %b", n, a_sready, (n >= 6)); end
      n_cmp++; if (a_rd !== (n >= 7)) begin n_bad++; $display("FAIL init_grant_gate edge %0d: sdr_rd got %b want %b", n, a_rd, (n >= 7)); end
    end
  endtask

  task automatic test_single_read();
    step();
    n_cmp++; if ({a_rd, a_we} !== 2'b10) begin n_bad++; $display("FAIL read_req: rd/we got %b want 10", {a_rd, a_we}); end
    n_cmp++; if (a_addr !== 21'h012345) begin n_bad++; $display("FAIL read_addr: got %h want 012345", a_addr); end
    rdy_a = 1'b0;
    step();
    n_cmp++; if ({a_rd, a_we} !== 2'b00) begin n_bad++; $display("FAIL read_busy_req: rd/we got %b want 00", {a_rd, a_we}); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (a_ack !== 3'b000 || a_addr !== 21'h012345) begin n_bad++; $display("FAIL read_busy_hold: ack=%b addr=%h want 000/012345", a_ack, a_addr); end
    end
    rdy_a = 1'b1; dout_v = 16'hBEEF;
    step();
    n_cmp++; if (a_ack !== 3'b001) begin n_bad++; $display("FAIL read_ack: got %b want 001", a_ack); end
    n_cmp++; if (a_rdat !== 16'hBEEF) begin n_bad++; $display("FAIL read_rdat: got %h want BEEF", a_rdat); end
    stb_a = '0;
    step();
    n_cmp++; if (a_ack !== 3'b000) begin n_bad++; $display("FAIL read_ack_single: got %b want 000", a_ack); end
  endtask

  task automatic test_byte_write();
    we_v[1] = 1'b1; sel_v[3:2] = 2'b01; adr_v[AW +: AW] = 21'h01ABCD; wdat_v[DW +: DW] = 16'h00AA;
    stb_a = 3'b010;
    step();
    n_cmp++; if ({a_we, a_rd} !== 2'b10) begin n_bad++; $display("FAIL wr_req: we/rd got %b want 10", {a_we, a_rd}); end
    n_cmp++; if (a_wtbt !== 2'b01) begin n_bad++; $display("FAIL wr_wtbt: got %b want 01", a_wtbt); end
    n_cmp++; if (a_din !== 16'h00AA || a_addr !== 21'h01ABCD) begin n_bad++; $display("FAIL wr_data: din=%h addr=%h want 00AA/01ABCD", a_din, a_addr); end
    stb_a = '0; rdy_a = 1'b0;
    step();
    n_cmp++; if (a_we !== 1'b0 || a_addr !== 21'h01ABCD || a_din !== 16'h00AA) begin n_bad++; $display("FAIL wr_busy_hold: we=%b addr=%h din=%h want 0/01ABCD/00AA", a_we, a_addr, a_din); end
    rdy_a = 1'b1; dout_v = 16'h1234;
    step();
    n_cmp++; if (a_ack !== 3'b010) begin n_bad++; $display("FAIL wr_ack: got %b want 010", a_ack); end
    n_cmp++; if (a_rdat !== 16'hBEEF) begin n_bad++; $display("FAIL wr_rdat_kept: got %h want BEEF", a_rdat); end
    step();
    we_v[1] = 1'b0;
  endtask

  task automatic do_reset();
    int t;
    reset = 1'b1; stb_a = '0; stb_b = '0; rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    t = 0;
    while (!(a_sready && b_sready) && t < 20) begin step(); t++; end
    n_cmp++; if (!(a_sready && b_sready)) begin n_bad++; $display("FAIL reinit_timeout: sdram_ready a=%b b=%b want 1/1", a_sready, b_sready); end
  endtask

  task automatic test_round_robin();
    int ga[6];
    int gb[3];
    int na, nb;
    do_reset();
    we_v = '0; na = 0; nb = 0;
    stb_a = 3'b111; stb_b = 3'b111;
    for (int cyc = 0; cyc < 60; cyc++) begin
      step();
      if (rdy_a && (a_rd || a_we)) rdy_a = 1'b0; else if (!rdy_a) rdy_a = 1'b1;
      if (rdy_b && (b_rd || b_we)) rdy_b = 1'b0; else if (!rdy_b) rdy_b = 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (1'(a_ack >> i)) begin if (na < 6) ga[na] = i; na++; end
        if (1'(b_ack >> i)) begin if (nb < 3) gb[nb] = i; nb++; end
      end
      stb_a = (na >= 6) ? 3'b000 : ~a_ack;
      stb_b = (nb >= 3) ? 3'b000 : ~b_ack;
    end
    n_cmp++; if (na !== 6) begin n_bad++; $display("FAIL rr_count: got %0d acks want 6", na); end
    n_cmp++; if (nb !== 3) begin n_bad++; $display("FAIL fixed_count: got %0d acks want 3", nb); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (k < na && ga[k] !== k % 3) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, ga[k], k % 3); end
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (k < nb && gb[k] !== 0) begin n_bad++; $display("FAIL fixed_order[%0d]: got %0d want 0", k, gb[k]); end
    end
    rdy_a = 1'b1; rdy_b = 1'b1;
  endtask

  task automatic test_reset_mid_busy();
    int t, acks;
    adr_v[2*AW +: AW] = 21'h000777;
    stb_a = 3'b001;
    step();
    n_cmp++; if (a_rd !== 1'b1) begin n_bad++; $display("FAIL rstb_req: sdr_rd got %b want 1", a_rd); end
    rdy_a = 1'b0; stb_a = '0;
    step();
    reset = 1'b1; rdy_a = 1'b1; dout_v = 16'hDEAD;
    step();
    n_cmp++; if ({a_rd, a_we, a_ack} !== 5'b0) begin n_bad++; $display("FAIL rstb_abort: rd/we/ack got %b want 0", {a_rd, a_we, a_ack}); end
    n_cmp++; if (a_init !== 1'b1 || a_sready !== 1'b0) begin n_bad++; $display("FAIL rstb_init: init=%b sdram_ready=%b want 1/0", a_init, a_sready); end
    step();
    reset = 1'b0; t = 0; acks = 0;
    while (!a_sready && t < 20) begin step(); t++; if (a_ack !== 3'b000) acks++; end
    n_cmp++; if (!a_sready || acks != 0) begin n_bad++; $display("FAIL rstb_no_ack: sdram_ready=%b acks=%0d want 1/0", a_sready, acks); end
    n_cmp++; if (a_rdat !== 16'h0000) begin n_bad++; $display("FAIL rstb_rdat: got %h want 0000", a_rdat); end
    stb_a = 3'b100;
    step();
    n_cmp++; if (a_rd !== 1'b1 || a_addr !== 21'h000777) begin n_bad++; $display("FAIL rstb_fresh_req: rd=%b addr=%h want 1/000777", a_rd, a_addr); end
    stb_a = '0; rdy_a = 1'b0;
    step();
    rdy_a = 1'b1; dout_v = 16'h5A5A;
    step();
    n_cmp++; if (a_ack !== 3'b100 || a_rdat !== 16'h5A5A) begin n_bad++; $display("FAIL rstb_fresh_ack: ack=%b rdat=%h want 100/5A5A", a_ack, a_rdat); end
    step();
  endtask

  task automatic test_stall();
    int bad, acks;
    adr_v[0 +: AW] = 21'h1FFFFF; we_v[0] = 1'b0; rdy_a = 1'b1;
    stb_a = 3'b001;
    step();
    stb_a = '0; bad = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (!(a_rd === 1'b1 && a_ack === 3'b000)) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL stall_hold: %0d bad cycles want 0", bad); end
    n_cmp++; if (a_addr !== 21'h1FFFFF) begin n_bad++; $display("FAIL stall_addr: got %h want 1FFFFF", a_addr); end
    rdy_a = 1'b0;
    step();
    rdy_a = 1'b1; dout_v = 16'hC3C3; acks = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (a_ack === 3'b001) acks++;
      else if (a_ack !== 3'b000) acks += 100;
    end
    n_cmp++; if (acks != 1) begin n_bad++; $display("FAIL stall_ack_count: got %0d want 1", acks); end
    n_cmp++; if (a_rdat !== 16'hC3C3) begin n_bad++; $display("FAIL stall_rdat: got %h want C3C3", a_rdat); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_read();
    test_byte_write();
    test_round_robin();
    test_reset_mid_busy();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Parametrised successor to the single-master SDRAM glue in the board top level. It arbitrates NCH bus masters onto one `sdram` controller port and converts each master's stb/we/sel/ack cycle into the controller's level-sensitive we/rd requests and its ready handshake. It owns the delayed controller-init sequence and the `sdram_ready` flag, replacing the ad-hoc dreset/dr_cnt/dack logic in the top level.

## Interface
Parameters:
- NCH, 2, number of master ports (1..8)
- AW, 21, word-address width (address bits [AW:1])
- DW, 16, data width
- INIT_DELAY, 3, clk_p cycles after reset release before `sdr_init` deasserts (1..255)
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = lowest index always wins

Ports:
- clk_p  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- ch_stb  in  NCH  per-master cycle strobe
- ch_we  in  NCH  per-master write enable
- ch_sel  in  2*NCH  byte selects, {hi,lo} per master
- ch_adr  in  NCH*AW  word addresses, master i at [i*AW +: AW]
- ch_wdat  in  NCH*DW  write data, master i at [i*DW +: DW]
- ch_rdat  out  DW  read data, shared by all masters, valid with ack
- ch_ack  out  NCH  one-cycle acknowledge to the granted master
- sdram_ready  out  1  SDRAM initialised flag
- sdr_init  out  1  controller init request
- sdr_we, sdr_rd  out  1 each  controller write / read request
- sdr_wtbt  out  2  controller byte-write mask
- sdr_addr  out  AW  controller word address
- sdr_din  out  DW  controller write data
- sdr_dout  in  DW  controller read data
- sdr_ready  in  1  controller ready; low while busy

## Operation
Init sequence:
- While reset is high: `sdr_init`=1, delay counter=0, `sdram_ready`=0.
- After reset is released, the counter increments each cycle. When it reaches INIT_DELAY, `sdr_init` drops to 0 and stays 0.
- `sdram_ready` sets on the first cycle in which `sdr_init`=0 and `sdr_ready`=1. It is sticky until reset.

FSM states: IDLE, REQ, BUSY, DONE.
- **IDLE:** if `sdram_ready`=1 and any `ch_stb` is set, select grant g and go to REQ.
  - Latch ch_adr[g], ch_wdat[g], ch_sel[g] and ch_we[g] into output registers on that same edge.
  - Otherwise stay in IDLE.
- **REQ:** drive `sdr_we` = latched we, or `sdr_rd` = ~latched we. Exactly one of the two is high.
  - On a cycle where `sdr_ready`=0 is sampled: drop the request and go to BUSY.
  - Otherwise hold the request indefinitely (no timeout).
- **BUSY:** on a cycle where `sdr_ready`=1 is sampled: register sdr_dout into `ch_rdat`, assert ch_ack[g], go to DONE.
- **DONE:** ch_ack[g] is high for this single cycle. Go to IDLE.

Arbitration:
- FIXED_PRIO=1: lowest asserted index wins.
- FIXED_PRIO=0: search starts at pointer p. After each grant, p = (g+1) mod NCH. p resets to 0.

Other rules:
- ch_stb is not re-checked after grant. A master dropping stb mid-cycle still completes its transfer.
- A master must drop stb on the edge after it sees ack. If stb is still high in IDLE, that is a new request.
- `sdr_wtbt` = latched sel. `sdr_addr` and `sdr_din` are held stable from REQ entry until IDLE.
- `ch_rdat` holds its last value until the next read completes. It is not updated on writes; write acks leave it unchanged.
- Reset mid-operation: on the next edge, FSM=IDLE, `sdr_we`=`sdr_rd`=0, ch_ack=0, `sdr_init`=1, `sdram_ready`=0. The outstanding transfer is abandoned without an ack.

## Timing
Reset values of outputs:
- 0: `ch_ack`, `ch_rdat`, `sdram_ready`, `sdr_we`, `sdr_rd`, `sdr_wtbt`, `sdr_addr`, `sdr_din`
- 1: `sdr_init`

Init: `sdr_init` falls INIT_DELAY+1 edges after the first edge sampling reset=0.

Transfer latency:
- stb sampled in IDLE at edge 0; request visible after edge 0.
- If the controller drops ready k cycles later and raises it b cycles after that, ack is high during the cycle after edge k+b+1.
- Minimum stb-to-ack is 3 edges.

Back-to-back grants:
- IDLE is always entered for at least one cycle between transfers.
- Minimum spacing is 4 cycles per transfer.

All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Init:** reset 5 cycles, then release; INIT_DELAY=3, sdr_ready tied to 1 -> `sdr_init` falls 4 edges after release; `sdram_ready`=1 one edge later; stb asserted earlier is not granted until then.
- **Single read:** NCH=2, ch0 reads adr 0x012345; model drops ready 1 cycle after the request, busy 4 cycles, dout 0xBEEF -> sdr_rd high only in REQ, ch_ack[0] one cycle, ch_rdat=0xBEEF, ch_ack[1]=0.
- **Byte write:** ch1 writes 0x00AA with sel=2'b01 -> sdr_we=1, sdr_wtbt=01, sdr_din=0x00AA, sdr_addr stable through BUSY; ch_rdat unchanged.
- **Round-robin:** NCH=3, all stb held continuously (re-asserted after each ack) -> grant order 0,1,2,0,1,2. With FIXED_PRIO=1 -> 0,0,0.
- **Reset mid-BUSY:** assert reset while in BUSY -> next edge sdr_rd/we=0, no ack ever issued, sdr_init=1; after re-init, a fresh request completes normally.
- **Stalled controller:** sdr_ready held high after the request -> request held in REQ for 100 cycles with no ack; a later ready low then high -> exactly one ack.
